// File: rtl/cv_change_sequencer.sv
// Change-return sequencer: pays a refund as dime/nickel ejector pulses, greedy dime-first,
// while tracking tube inventory so an empty tube is never fired.
module cv_change_sequencer #(
    parameter int unsigned AMT_W        = 6,
    parameter int unsigned TUBE_W       = 6,
    parameter int unsigned INIT_NICKELS = 10,
    parameter int unsigned INIT_DIMES   = 10,
    parameter int unsigned GAP          = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [AMT_W-1:0]  refund_units,
    input  logic              nickel_in,
    input  logic              dime_in,
    output logic              n,
    output logic              d,
    output logic              busy,
    output logic              done,
    output logic              short,
    output logic [AMT_W-1:0]  remaining,
    output logic [TUBE_W-1:0] nickel_cnt,
    output logic [TUBE_W-1:0] dime_cnt
);

    typedef enum logic [1:0] {StIdle, StDispense, StGap} state_e;

    localparam logic [TUBE_W-1:0] TubeMax = '1;
    localparam logic [3:0]        GapLoad = 4'(GAP);

    state_e            state_q, state_d;
    logic [3:0]        gap_q, gap_d;
    logic              n_q, n_d, d_q, d_d;
    logic              busy_q, busy_d, done_q, done_d, short_q, short_d;
    logic [AMT_W-1:0]  rem_q, rem_d;
    logic [TUBE_W-1:0] nickel_q, nickel_d, dime_q, dime_d;
    logic              take_dime, take_nickel;

    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        n_d         = 1'b0;
        d_d         = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        short_d     = short_q;
        rem_d       = rem_q;
        take_dime   = 1'b0;
        take_nickel = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    rem_d   = refund_units;
                    busy_d  = 1'b1;
                    short_d = 1'b0;
                    state_d = StDispense;
                end
            end
            StDispense: begin
                if (rem_q >= AMT_W'(2) && dime_q != '0) begin
                    take_dime = 1'b1;
                    d_d       = 1'b1;
                    rem_d     = rem_q - AMT_W'(2);
                end else if (rem_q != '0 && nickel_q != '0) begin
                    take_nickel = 1'b1;
                    n_d         = 1'b1;
                    rem_d       = rem_q - AMT_W'(1);
                end else begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    short_d = (rem_q != '0);
                    state_d = StIdle;
                end
                if ((take_dime || take_nickel) && GAP != 0) begin
                    state_d = StGap;
                    gap_d   = GapLoad;
                end
            end
            StGap: begin
                if (gap_q <= 4'd1) begin
                    state_d = StDispense;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Refill and dispense of the same coin on one edge cancel out.
    always_comb begin
        nickel_d = nickel_q;
        if (nickel_in && !take_nickel) begin
            if (nickel_q != TubeMax) nickel_d = nickel_q + TUBE_W'(1);
        end else if (!nickel_in && take_nickel) begin
            nickel_d = nickel_q - TUBE_W'(1);
        end
        dime_d = dime_q;
        if (dime_in && !take_dime) begin
            if (dime_q != TubeMax) dime_d = dime_q + TUBE_W'(1);
        end else if (!dime_in && take_dime) begin
            dime_d = dime_q - TUBE_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            gap_q    <= '0;
            n_q      <= 1'b0;
            d_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            short_q  <= 1'b0;
            rem_q    <= '0;
            nickel_q <= TUBE_W'(INIT_NICKELS);
            dime_q   <= TUBE_W'(INIT_DIMES);
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            n_q      <= n_d;
            d_q      <= d_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            short_q  <= short_d;
            rem_q    <= rem_d;
            nickel_q <= nickel_d;
            dime_q   <= dime_d;
        end
    end

    assign n          = n_q;
    assign d          = d_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign short      = short_q;
    assign remaining  = rem_q;
    assign nickel_cnt = nickel_q;
    assign dime_cnt   = dime_q;

endmodule

// File: doc/cv_change_sequencer.md
# cv_change_sequencer

Sequences change return for the candy vending machine. It takes a refund amount from the vending FSM, dispenses it as one-cycle `n` (nickel) and `d` (dime) ejector pulses using a greedy dime-first policy, and tracks coin-tube inventory so it never fires an ejector for an empty tube. It sits between the vending FSM and the `n`/`d` DUT outputs and is the only block allowed to drive the ejectors. Accepted `nickel`/`dime` coins refill the tubes.

## Interface
- `AMT_W`, default 6: width of the refund amount, in nickel units (1 unit = 5 cents).
- `TUBE_W`, default 6: width of each tube counter; each counter saturates at 2^TUBE_W-1.
- `INIT_NICKELS`, default 10: nickel tube count after reset.
- `INIT_DIMES`, default 10: dime tube count after reset.
- `GAP`, default 1: idle cycles forced after every ejector pulse, range 0..15.

Ports:
- `clock` input 1: single clock for the block, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: request to dispense; sampled only in IDLE.
- `refund_units` input AMT_W: amount to return; captured when `start` is accepted.
- `nickel_in` input 1: one accepted nickel this cycle; refills the nickel tube.
- `dime_in` input 1: one accepted dime this cycle; refills the dime tube.
- `n` output 1: nickel ejector pulse, registered.
- `d` output 1: dime ejector pulse, registered.
- `busy` output 1: a request is in progress.
- `done` output 1: one-cycle completion pulse.
- `short` output 1: the last request ended with an undispensed remainder. Holds until the next accepted `start`.
- `remaining` output AMT_W: undispensed units, valid while `busy` and after `done`.
- `nickel_cnt`, `dime_cnt` output TUBE_W each: tube inventory.

## Operation
States are IDLE, DISPENSE, GAP. All outputs are registered.

Reset values: `n`=0, `d`=0, `busy`=0, `done`=0, `short`=0, `remaining`=0, `nickel_cnt`=INIT_NICKELS, `dime_cnt`=INIT_DIMES, state IDLE, gap counter 0.

**IDLE**
- When `start`=1: capture `remaining`<=`refund_units`, set `busy`<=1, `short`<=0, and go to DISPENSE.
- When `start`=1 arrives in any other state, it is ignored.

**DISPENSE** — one decision per edge, in priority order:
1. If `remaining`>=2 and `dime_cnt`>0: `d`<=1, `remaining`-=2, `dime_cnt`-=1.
2. Else if `remaining`>=1 and `nickel_cnt`>0: `n`<=1, `remaining`-=1, `nickel_cnt`-=1.
3. Else: `done`<=1, `busy`<=0, `short`<=(`remaining`!=0), go to IDLE. `remaining` keeps its residual value.

After cases 1 and 2:
- If GAP>0, go to GAP and load the gap counter with GAP.
- If GAP=0, stay in DISPENSE.

**GAP**
- Decrement the gap counter each edge; return to DISPENSE when it reaches 1.
- `n`/`d` are 0 throughout GAP.

**Pulses and exclusivity**
- `n` and `d` are each high for exactly one cycle per coin.
- `n` and `d` are never high in the same cycle.

**Refill**
- On any edge, `nickel_in`/`dime_in` increment their counter, saturating at the maximum.
- Refill and dispense of the same coin type on the same edge give a net change of 0.
- A refill is visible to the DISPENSE decision on the following edge.

**Dime shortage**
- When no dimes remain, `remaining`>=2 is paid in nickels one unit at a time.
- An odd remainder with zero nickels produces `short`=1.

**Other rules**
- `refund_units`=0 completes without any pulse and with `short`=0.
- Asserting `reset` mid-request aborts it immediately. No further pulses are issued and tube counts revert to INIT values.

## Timing
- Accept: `start` high at edge E0 gives `busy`=1 from E0.
- First decision is at E1; the first pulse is visible in cycle E1..E2.
- Pulse spacing: one coin per (1+GAP) cycles.
- Completion: for k coins, `done` asserts at edge E0 + 1 + k·(1+GAP). It is high for one cycle, coincident with `busy` falling.
- Back-to-back: a new `start` can be accepted on the edge after `done` is seen (first IDLE cycle).
- Inputs `nickel_in`, `dime_in`, `start`, `refund_units` are synchronous to `clock` and sampled at the rising edge.

## Test plan
- Reset values: assert `reset`=0 asynchronously mid-cycle -> all outputs go to reset values immediately; `nickel_cnt`=10, `dime_cnt`=10.
- Mixed change: `refund_units`=3, GAP=1 -> `d` pulse at E1, `n` pulse at E3, `done` at E5, `short`=0, `dime_cnt`=9, `nickel_cnt`=9.
- Dime exhaustion: preload `dime_cnt`=1, `refund_units`=6 -> 1 `d` pulse then 4 `n` pulses, `remaining`=0, `short`=0.
- Shortage: `dime_cnt`=0, `nickel_cnt`=2, `refund_units`=5 -> 2 `n` pulses, then `done` with `short`=1, `remaining`=3; `short` clears on the next `start`.
- Refill during dispense: `dime_cnt`=0, `nickel_cnt`=0, `refund_units`=2 with `dime_in`=1 pulsed at E0 -> a `d` pulse at E1 and `dime_cnt` returns to 0. Also `dime_in` on the same edge as a `d` decision -> count unchanged. Also `nickel_in` with the count at 63 -> stays 63.
- Protocol: `start` while `busy` is ignored; `refund_units`=0 -> `done` at E1 with no pulses; reset asserted at E2 of a 4-dime request -> no pulses after reset and tube counts back to INIT.
